// File: rtl/ped_crossing.sv
// Pedestrian crossing controller slaved to a red/amber/green traffic stage.
// Optional audible aid on the chirp output is built only when PED_CHIRP_EN is defined.
module ped_crossing #(
  parameter int WALK_CYCLES  = 4,
  parameter int FLASH_CYCLES = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic red,
  input  logic amber,
  input  logic green,
  input  logic button,
  output logic walk,
  output logic dont_walk,
  output logic wait_lamp,
  output logic fault,
  output logic chirp
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_WAIT,
    S_WALK,
    S_FLASH,
    S_FAULT
  } state_t;

  localparam logic [7:0] WALK_LOAD  = 8'(WALK_CYCLES - 1);
  localparam logic [7:0] FLASH_LOAD = 8'(FLASH_CYCLES - 1);

  state_t     state_reg;
  logic [7:0] cnt_reg;
  logic       pending_reg;
  logic [2:0] rag;
  logic       safe;
  logic       legal;
  logic       pending_next;

  assign rag          = {red, amber, green};
  assign safe         = (rag == 3'b100);
  assign legal        = (rag == 3'b100) || (rag == 3'b110) ||
                        (rag == 3'b001) || (rag == 3'b010);
  assign pending_next = pending_reg | button;

`ifndef PED_CHIRP_EN
  assign chirp = 1'b0;
`endif

  // Outputs default to the safe don't-walk pattern; each branch overrides what it lights.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_reg   <= S_IDLE;
      cnt_reg     <= 8'd0;
      pending_reg <= 1'b0;
      walk        <= 1'b0;
      dont_walk   <= 1'b1;
      wait_lamp   <= 1'b0;
      fault       <= 1'b0;
`ifdef PED_CHIRP_EN
      chirp       <= 1'b0;
`endif
    end else begin
      walk      <= 1'b0;
      dont_walk <= 1'b1;
      wait_lamp <= 1'b0;
      fault     <= 1'b0;
`ifdef PED_CHIRP_EN
      chirp     <= 1'b0;
`endif
      if (!legal) begin
        state_reg <= S_FAULT;
        fault     <= 1'b1;
      end else begin
        case (state_reg)
          S_IDLE: begin
            if (button) begin
              state_reg   <= S_WAIT;
              pending_reg <= 1'b0;
              wait_lamp   <= 1'b1;
            end
          end
          S_WAIT: begin
            if (safe) begin
              state_reg <= S_WALK;
              cnt_reg   <= WALK_LOAD;
              walk      <= 1'b1;
              dont_walk <= 1'b0;
`ifdef PED_CHIRP_EN
              chirp     <= 1'b1;
`endif
            end else begin
              wait_lamp <= 1'b1;
            end
          end
          S_WALK: begin
            if (!safe) begin
              // Abort re-arms the request so the walk resumes once the stage is red again.
              state_reg   <= S_WAIT;
              pending_reg <= 1'b0;
              wait_lamp   <= 1'b1;
            end else begin
              dont_walk   <= 1'b0;
              wait_lamp   <= pending_next;
              pending_reg <= pending_next;
              if (cnt_reg == 8'd0) begin
                state_reg <= S_FLASH;
                cnt_reg   <= FLASH_LOAD;
`ifdef PED_CHIRP_EN
                chirp     <= 1'b1;
`endif
              end else begin
                cnt_reg <= cnt_reg - 8'd1;
                walk    <= 1'b1;
`ifdef PED_CHIRP_EN
                chirp   <= ~chirp;
`endif
              end
            end
          end
          S_FLASH: begin
            if (!safe) begin
              state_reg <= S_IDLE;
            end else if (cnt_reg == 8'd0) begin
              if (pending_next) begin
                state_reg   <= S_WAIT;
                pending_reg <= 1'b0;
                wait_lamp   <= 1'b1;
              end else begin
                state_reg <= S_IDLE;
              end
            end else begin
              cnt_reg     <= cnt_reg - 8'd1;
              dont_walk   <= 1'b0;
              walk        <= ~walk;
              wait_lamp   <= pending_next;
              pending_reg <= pending_next;
`ifdef PED_CHIRP_EN
              // Walk is high on every second flash cycle, halving the chirp rate.
              chirp       <= walk ? ~chirp : chirp;
`endif
            end
          end
          S_FAULT: begin
            fault <= 1'b1;
          end
          default: begin
            state_reg <= S_FAULT;
            fault     <= 1'b1;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_ped_crossing.sv
// Self-checking bench for ped_crossing: directed scenarios plus randomized traffic
// compared cycle by cycle against an elapsed-time reference model.
module tb_ped_crossing;
  localparam int WALK_CYCLES  = 4;
  localparam int FLASH_CYCLES = 2;

  localparam int M_IDLE  = 0;
  localparam int M_WAIT  = 1;
  localparam int M_WALK  = 2;
  localparam int M_FLASH = 3;
  localparam int M_FAULT = 4;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [2:0] rag_drv = 3'b001;
  logic       button = 1'b0;
  logic       walk, dont_walk, wait_lamp, fault, chirp;
  logic [4:0] obs;

  int checks = 0;
  int fails  = 0;

  int m_mode    = M_IDLE;
  int m_elapsed = 0;
  bit m_pend    = 1'b0;

  ped_crossing #(.WALK_CYCLES(WALK_CYCLES), .FLASH_CYCLES(FLASH_CYCLES)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .red       (rag_drv[2]),
    .amber     (rag_drv[1]),
    .green     (rag_drv[0]),
    .button    (button),
    .walk      (walk),
    .dont_walk (dont_walk),
    .wait_lamp (wait_lamp),
    .fault     (fault),
    .chirp     (chirp)
  );

  assign obs = {walk, dont_walk, wait_lamp, fault, chirp};

  always #5 clk = ~clk;

  // Reference model: phases measured by elapsed cycles, lamps derived arithmetically.
  function automatic void model_step(input logic rn, input logic [2:0] r, input logic b);
    bit safe_v, legal_v;
    safe_v  = (r == 3'b100);
    legal_v = (r == 3'b100) || (r == 3'b110) || (r == 3'b001) || (r == 3'b010);
    if (!rn) begin
      m_mode = M_IDLE; m_elapsed = 0; m_pend = 1'b0;
    end else if (!legal_v) begin
      m_mode = M_FAULT;
    end else begin
      case (m_mode)
        M_IDLE: if (b) begin m_mode = M_WAIT; m_pend = 1'b0; end
        M_WAIT: if (safe_v) begin m_mode = M_WALK; m_elapsed = 0; end
        M_WALK: begin
          m_pend = m_pend | b;
          if (!safe_v) begin m_mode = M_WAIT; m_pend = 1'b0; end
          else if (m_elapsed == WALK_CYCLES - 1) begin m_mode = M_FLASH; m_elapsed = 0; end
          else m_elapsed++;
        end
        M_FLASH: begin
          m_pend = m_pend | b;
          if (!safe_v) m_mode = M_IDLE;
          else if (m_elapsed == FLASH_CYCLES - 1) begin
            if (m_pend) begin m_mode = M_WAIT; m_pend = 1'b0; end
            else m_mode = M_IDLE;
          end else m_elapsed++;
        end
        default: m_mode = M_FAULT;
      endcase
    end
  endfunction

  function automatic logic [4:0] exp_out();
    logic w, dw, wl, f, ch;
    w  = (m_mode == M_WALK) || (m_mode == M_FLASH && (m_elapsed % 2) == 1);
    dw = !(m_mode == M_WALK || m_mode == M_FLASH);
    wl = (m_mode == M_WAIT) || ((m_mode == M_WALK || m_mode == M_FLASH) && m_pend);
    f  = (m_mode == M_FAULT);
    ch = 1'b0;
`ifdef PED_CHIRP_EN
    if (m_mode == M_WALK)  ch = ((m_elapsed % 2) == 0);
    if (m_mode == M_FLASH) ch = (((m_elapsed / 2) % 2) == 0);
`endif
    return {w, dw, wl, f, ch};
  endfunction

  task automatic cycle(input logic rn, input logic [2:0] r, input logic b);
    @(negedge clk);
    rst_n = rn; rag_drv = r; button = b;
    @(posedge clk);
    model_step(rn, r, b);
    #1;
  endtask

  task automatic test_reset();
    for (int i = 0; i < 2; i++) begin
      cycle(1'b0, 3'b001, 1'b0);
      checks++;
      if (obs !== 5'b01000) begin
        fails++;
        $display("FAIL reset[%0d]: got %b need %b (walk,dont_walk,wait,fault,chirp)", i, obs, 5'b01000);
      end
    end
    $display("reset: outputs %b", obs);
  endtask

  task automatic test_walk_cycle();
    int walk_hi = 0;
    cycle(1'b1, 3'b100, 1'b1);
    checks++;
    if (wait_lamp !== 1'b1 || walk !== 1'b0) begin
      fails++;
      $display("FAIL latency_wait: got wait=%b walk=%b need wait=1 walk=0", wait_lamp, walk);
    end
    for (int i = 0; i < 10; i++) begin
      cycle(1'b1, 3'b100, 1'b0);
      if (i == 0) begin
        checks++;
        if (walk !== 1'b1) begin
          fails++;
          $display("FAIL latency_walk: got %b need 1", walk);
        end
      end
      walk_hi += int'(walk);
      checks++;
      if (obs !== exp_out()) begin
        fails++;
        $display("FAIL walk_cycle[%0d]: got %b need %b", i, obs, exp_out());
      end
    end
    checks++;
    if (walk_hi != WALK_CYCLES + FLASH_CYCLES / 2) begin
      fails++;
      $display("FAIL walk_count: got %0d need %0d", walk_hi, WALK_CYCLES + FLASH_CYCLES / 2);
    end
    $display("walk_cycle: walk lit %0d cycles", walk_hi);
  endtask

  task automatic test_late_safe();
    logic [2:0] seq [8] = '{3'b001, 3'b001, 3'b010, 3'b100, 3'b100, 3'b100, 3'b100, 3'b100};
    cycle(1'b1, 3'b001, 1'b1);
    for (int i = 0; i < 8; i++) begin
      cycle(1'b1, seq[i], 1'b0);
      checks++;
      if (obs !== exp_out()) begin
        fails++;
        $display("FAIL late_safe[%0d]: got %b need %b", i, obs, exp_out());
      end
    end
    $display("late_safe: done, outputs %b", obs);
  endtask

  task automatic test_abort();
    logic [2:0] seq [10] = '{3'b100, 3'b100, 3'b110, 3'b001, 3'b010, 3'b100,
                             3'b100, 3'b100, 3'b100, 3'b100};
    cycle(1'b1, 3'b100, 1'b1);
    for (int i = 0; i < 10; i++) begin
      cycle(1'b1, seq[i], 1'b0);
      checks++;
      if (obs !== exp_out()) begin
        fails++;
        $display("FAIL abort[%0d]: got %b need %b", i, obs, exp_out());
      end
    end
    $display("abort: done, outputs %b", obs);
  endtask

  task automatic test_back_to_back();
    for (int i = 0; i < 16; i++) begin
      cycle(1'b1, 3'b100, (i == 0) || (i == 3));
      checks++;
      if (obs !== exp_out()) begin
        fails++;
        $display("FAIL back_to_back[%0d]: got %b need %b", i, obs, exp_out());
      end
    end
    $display("back_to_back: done, outputs %b", obs);
  endtask

  task automatic test_fault();
    cycle(1'b1, 3'b100, 1'b1);
    cycle(1'b1, 3'b100, 1'b0);
    cycle(1'b1, 3'b100, 1'b0);
    cycle(1'b1, 3'b101, 1'b0);
    for (int i = 0; i < 4; i++) begin
      cycle(1'b1, 3'b100, 1'b1);
      checks++;
      if (obs !== 5'b01010 || obs !== exp_out()) begin
        fails++;
        $display("FAIL fault_hold[%0d]: got %b need %b", i, obs, 5'b01010);
      end
    end
    cycle(1'b0, 3'b111, 1'b0);
    checks++;
    if (obs !== 5'b01000) begin
      fails++;
      $display("FAIL fault_clear: got %b need %b", obs, 5'b01000);
    end
    $display("fault: cleared by reset, outputs %b", obs);
  endtask

  task automatic test_random();
    logic [2:0] illegal [4] = '{3'b000, 3'b011, 3'b101, 3'b111};
    logic [2:0] r;
    logic rn, b;
    int pick;
    for (int i = 0; i < 3000; i++) begin
      pick = $urandom_range(0, 199);
      if (pick < 130) r = 3'b100;
      else if (pick < 155) r = 3'b110;
      else if (pick < 175) r = 3'b001;
      else if (pick < 198) r = 3'b010;
      else r = illegal[$urandom_range(0, 3)];
      rn = ($urandom_range(0, 99) >= 2);
      b  = ($urandom_range(0, 99) < 25);
      cycle(rn, r, b);
      checks++;
      if (obs !== exp_out() || (walk && dont_walk)) begin
        fails++;
        $display("FAIL random[%0d]: rag=%b btn=%b rst_n=%b got %b need %b", i, r, b, rn, obs, exp_out());
      end
    end
    $display("random: 3000 cycles compared");
  endtask

  initial begin
    test_reset();
    test_walk_cycle();
    test_late_safe();
    test_abort();
    test_back_to_back();
    test_fault();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
